// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter slice.
// Holds the default width and the per-edge operation encoding.
package counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 8;

  typedef logic [1:0] cnt_op_t;

  localparam cnt_op_t OP_HOLD = 2'd0;
  localparam cnt_op_t OP_CLR  = 2'd1;
  localparam cnt_op_t OP_LOAD = 2'd2;
  localparam cnt_op_t OP_STEP = 2'd3;

  // CLR beats LOAD beats EN; nothing asserted means hold.
  function automatic cnt_op_t decode_op(
    input logic clr,
    input logic load,
    input logic en
  );
    cnt_op_t op;
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_STEP;
    end
    return op;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational step value for the modulus counter.
// Ports: q_i, up_i, limit_i in; nxt_o (value after one step), wrap_hit_o out.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             wrap_hit_o
);

  logic up_wrap;
  logic dn_wrap;

  // Up wraps on >= so a lowered limit below q snaps back to 0.
  assign up_wrap = (q_i >= limit_i);
  assign dn_wrap = (q_i == '0);

  always_comb begin
    nxt_o      = q_i;
    wrap_hit_o = 1'b0;
    if (up_i) begin
      wrap_hit_o = up_wrap;
      nxt_o      = up_wrap ? '0 : q_i + WIDTH'(1);
    end else begin
      wrap_hit_o = dn_wrap;
      nxt_o      = dn_wrap ? limit_i : q_i - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_updn_mod.sv
// Synchronous up/down counter with modulus, load, clear and wrap flags.
// Ports: CLK, RST(n), EN, UP, LOAD, D, CLR, LIMIT in; Q, NQ, TC, WRAP, OVF out.
module counter_updn_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NQ,
  output logic             TC,
  output logic             WRAP,
  output logic             OVF
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             ovf_q;
  logic             ovf_d;

  cnt_op_t          op;
  logic [WIDTH-1:0] step_val;
  logic             wrap_hit;

  counter_next_val #(
    .WIDTH(WIDTH)
  ) u_next (
    .q_i       (cnt_q),
    .up_i      (UP),
    .limit_i   (LIMIT),
    .nxt_o     (step_val),
    .wrap_hit_o(wrap_hit)
  );

  assign op = decode_op(CLR, LOAD, EN);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    case (op)
      OP_CLR: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      OP_LOAD: begin
        cnt_d = D;
      end
      OP_STEP: begin
        cnt_d  = step_val;
        wrap_d = wrap_hit;
        ovf_d  = ovf_q | wrap_hit;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  // TC predicts WRAP for the coming edge.
  assign TC   = (op == OP_STEP) & wrap_hit;
  assign Q    = cnt_q;
  assign NQ   = ~cnt_q;
  assign WRAP = wrap_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_counter_updn_mod.sv
// Directed bench for counter_updn_mod.
// One task per scenario, each checking its own vectors.
module tb_counter_updn_mod;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       UP;
  logic       LOAD;
  logic [7:0] D;
  logic       CLR;
  logic [7:0] LIMIT;
  logic [7:0] Q;
  logic [7:0] NQ;
  logic       TC;
  logic       WRAP;
  logic       OVF;

  int total = 0;
  int bad   = 0;

  counter_updn_mod #(
    .WIDTH(8)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .UP   (UP),
    .LOAD (LOAD),
    .D    (D),
    .CLR  (CLR),
    .LIMIT(LIMIT),
    .Q    (Q),
    .NQ   (NQ),
    .TC   (TC),
    .WRAP (WRAP),
    .OVF  (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b0; EN = 1'b0; UP = 1'b1; LOAD = 1'b0;
    D = 8'd0; CLR = 1'b0; LIMIT = 8'd9;
    #2;
    total++;
    if (Q !== 8'd0 || NQ !== 8'hFF || WRAP !== 1'b0 || OVF !== 1'b0) begin
      bad++;
      $display("FAIL reset: Q=%0d NQ=%h WRAP=%b OVF=%b want 0 ff 0 0",
               Q, NQ, WRAP, OVF);
    end
    tick();
  endtask

  task automatic test_up_count;
    logic [7:0] eq;
    logic       ew;
    logic       eo;
    logic       etc;
    eq = 8'd0; ew = 1'b0; eo = 1'b0;
    RST = 1'b1; LIMIT = 8'd9; UP = 1'b1; EN = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      etc = (eq == 8'd9);
      total++;
      if (TC !== etc) begin
        bad++;
        $display("FAIL up_tc[%0d]: TC=%b want %b", i, TC, etc);
      end
      tick();
      ew = etc;
      eo = eo | etc;
      eq = etc ? 8'd0 : eq + 8'd1;
      total++;
      if (Q !== eq || NQ !== ~eq || WRAP !== ew || OVF !== eo) begin
        bad++;
        $display("FAIL up[%0d]: Q=%0d NQ=%h W=%b O=%b want %0d %h %b %b",
                 i, Q, NQ, WRAP, OVF, eq, ~eq, ew, eo);
      end
    end
  endtask

  task automatic test_down_wrap;
    logic [7:0] qs [3];
    logic       ws [3];
    qs = '{8'd0, 8'd5, 8'd4};
    ws = '{1'b0, 1'b1, 1'b0};
    EN = 1'b0; LIMIT = 8'd5; LOAD = 1'b1; D = 8'd1;
    tick();
    total++;
    if (Q !== 8'd1 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL dn_load: Q=%0d W=%b want 1 0", Q, WRAP);
    end
    LOAD = 1'b0; UP = 1'b0; EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (Q !== qs[i] || WRAP !== ws[i]) begin
        bad++;
        $display("FAIL dn[%0d]: Q=%0d W=%b want %0d %b",
                 i, Q, WRAP, qs[i], ws[i]);
      end
    end
  endtask

  task automatic test_load_above;
    EN = 1'b0; LIMIT = 8'd3; LOAD = 1'b1; D = 8'd200;
    tick();
    total++;
    if (Q !== 8'd200 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL ld200: Q=%0d W=%b want 200 0", Q, WRAP);
    end
    LOAD = 1'b0; UP = 1'b1; EN = 1'b1;
    #1;
    total++;
    if (TC !== 1'b1) begin
      bad++;
      $display("FAIL ld200_tc: TC=%b want 1", TC);
    end
    tick();
    total++;
    if (Q !== 8'd0 || WRAP !== 1'b1) begin
      bad++;
      $display("FAIL ld200_up: Q=%0d W=%b want 0 1", Q, WRAP);
    end
    EN = 1'b0; LOAD = 1'b1;
    tick();
    LOAD = 1'b0; UP = 1'b0; EN = 1'b1;
    tick();
    total++;
    if (Q !== 8'd199 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL ld200_dn: Q=%0d W=%b want 199 0", Q, WRAP);
    end
  endtask

  task automatic test_priority;
    EN = 1'b0; LOAD = 1'b1; D = 8'd7;
    tick();
    total++;
    if (Q !== 8'd7 || OVF !== 1'b1) begin
      bad++;
      $display("FAIL pri_pre: Q=%0d O=%b want 7 1", Q, OVF);
    end
    CLR = 1'b1; LOAD = 1'b1; EN = 1'b1; UP = 1'b1; D = 8'd4;
    #1;
    total++;
    if (TC !== 1'b0) begin
      bad++;
      $display("FAIL pri_tc: TC=%b want 0", TC);
    end
    tick();
    total++;
    if (Q !== 8'd0 || OVF !== 1'b0 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL pri_clr: Q=%0d O=%b W=%b want 0 0 0", Q, OVF, WRAP);
    end
    CLR = 1'b0;
    tick();
    total++;
    if (Q !== 8'd4 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL pri_ld: Q=%0d W=%b want 4 0", Q, WRAP);
    end
    LOAD = 1'b0; EN = 1'b0;
  endtask

  task automatic test_full_range;
    LIMIT = 8'd255; LOAD = 1'b1; D = 8'd255;
    tick();
    LOAD = 1'b0; UP = 1'b1; EN = 1'b1;
    tick();
    total++;
    if (Q !== 8'd0 || WRAP !== 1'b1 || OVF !== 1'b1) begin
      bad++;
      $display("FAIL full_up: Q=%0d W=%b O=%b want 0 1 1", Q, WRAP, OVF);
    end
    UP = 1'b0;
    tick();
    total++;
    if (Q !== 8'd255 || WRAP !== 1'b1) begin
      bad++;
      $display("FAIL full_dn: Q=%0d W=%b want 255 1", Q, WRAP);
    end
    LIMIT = 8'd0; UP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (Q !== 8'd0 || WRAP !== 1'b1 || TC !== 1'b1) begin
        bad++;
        $display("FAIL lim0[%0d]: Q=%0d W=%b TC=%b want 0 1 1",
                 i, Q, WRAP, TC);
      end
    end
  endtask

  task automatic test_async_reset;
    EN = 1'b0; LIMIT = 8'd9; LOAD = 1'b1; D = 8'd6;
    tick();
    LOAD = 1'b0;
    total++;
    if (Q !== 8'd6 || OVF !== 1'b1) begin
      bad++;
      $display("FAIL ar_pre: Q=%0d O=%b want 6 1", Q, OVF);
    end
    #2;
    RST = 1'b0;
    #1;
    total++;
    if (Q !== 8'd0 || NQ !== 8'hFF || OVF !== 1'b0 || WRAP !== 1'b0) begin
      bad++;
      $display("FAIL ar_mid: Q=%0d NQ=%h O=%b W=%b want 0 ff 0 0",
               Q, NQ, OVF, WRAP);
    end
    #2;
    RST = 1'b1; UP = 1'b1; EN = 1'b1;
    #1;
    total++;
    if (Q !== 8'd0) begin
      bad++;
      $display("FAIL ar_rel: Q=%0d want 0", Q);
    end
    tick();
    total++;
    if (Q !== 8'd1 || OVF !== 1'b0) begin
      bad++;
      $display("FAIL ar_resume: Q=%0d O=%b want 1 0", Q, OVF);
    end
    tick();
    total++;
    if (Q !== 8'd2) begin
      bad++;
      $display("FAIL ar_resume2: Q=%0d want 2", Q);
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_above();
    test_priority();
    test_full_range();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_updn_mod.md
Name: counter_updn_mod

Overview:
Parametrised synchronous up/down counter with programmable modulus, parallel load, sync clear, terminal-count and wrap flags. Successor to the fixed 8-bit ripple counter.
- All bits change on the same CLK edge; no ripple-clock stages.
- Used as timebase, event counter and loop counter by the arithmetic-unit datapath and control logic.
- Provides true and complemented count outputs.

Parameters:
WIDTH, 8, counter width in bits (legal range 2..32)

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous, active-low reset
EN  input  1  count enable, one step per CLK edge while high
UP  input  1  direction: 1 = count up, 0 = count down
LOAD  input  1  synchronous parallel load of D
D  input  WIDTH  load value
CLR  input  1  synchronous clear of count and sticky flag
LIMIT  input  WIDTH  terminal value; the count cycle is 0..LIMIT
Q  output  WIDTH  current count, registered
NQ  output  WIDTH  bitwise complement of Q
TC  output  1  terminal count, combinational: next enabled step wraps
WRAP  output  1  registered one-cycle pulse after a wrap occurred
OVF  output  1  sticky wrap flag, registered

Behaviour:
- Reset (RST low, asynchronous):
  - Q=0, NQ=all ones, WRAP=0, OVF=0.
  - Release is synchronous to the next CLK edge; the first update happens on the first edge after RST goes high.
- Per-edge priority is CLR > LOAD > EN; idle holds.
  - CLR: Q<=0, OVF<=0, WRAP<=0.
  - LOAD (CLR low): Q<=D, WRAP<=0, OVF unchanged. D may exceed LIMIT.
  - EN, UP=1:
    - If Q>=LIMIT: Q<=0, WRAP<=1, OVF<=1.
    - Else Q<=Q+1.
  - EN, UP=0:
    - If Q==0: Q<=LIMIT, WRAP<=1, OVF<=1.
    - Else Q<=Q-1.
    - Q>LIMIT decrements normally.
  - EN low, no CLR or LOAD: Q holds, WRAP<=0, OVF holds.
- WRAP is high for exactly one cycle per wrap. Back-to-back wraps, for example LIMIT=0 with EN held high, keep WRAP high continuously.
- TC = EN & ~CLR & ~LOAD & ((UP & Q>=LIMIT) | (~UP & Q==0)).
  - Combinational, no latency.
  - TC high means WRAP goes high after the next edge.
- NQ = ~Q, derived from the register with no extra cycle of latency.
- LIMIT may change at any time and is sampled on every edge.
  - Lowering LIMIT below Q forces a wrap to 0 on the next up step.
- LIMIT = 2^WIDTH-1 gives the full natural binary range. At that limit, up-wrap at all ones and down-wrap at 0 both load the opposite end.
- Arithmetic is unsigned, WIDTH bits. No carry beyond WIDTH is ever produced.
- RST asserted mid-count overrides everything immediately, regardless of CLK.
- Simultaneous CLR, LOAD and EN: CLR wins, and OVF clears even if a wrap condition was present.

Decomposition:
- Shared package counter_pkg:
  - CNT_WIDTH_DEFAULT = 8.
  - Localparams for priority op encoding: OP_HOLD, OP_CLR, OP_LOAD, OP_STEP.
- Sub-module counter_next_val:
  - Purely combinational.
  - Inputs: Q, UP, LIMIT. Outputs: next step value, wrap_hit.
  - Reused for TC generation.
- Top-level contents: op decode, state registers (Q, WRAP, OVF), NQ assignment.

Test Plan:
1. Reset and up-count: RST low, then high; LIMIT=9, UP=1, EN=1 for 12 edges.
   - Q follows 0..9, 0, 1.
   - TC high while Q=9; WRAP high exactly one cycle, at Q=0; OVF stays 1.
   - NQ=~Q on every cycle.
2. Down-count wrap: LIMIT=5, load D=1, UP=0, EN=1.
   - Q follows 1, 0, 5, 4.
   - WRAP pulses when Q=5.
3. Load above limit: LIMIT=3, LOAD D=200, then UP=1 EN=1.
   - Q follows 200, 0, with WRAP=1.
   - Same load with UP=0: Q follows 200, 199.
4. Priority: CLR=LOAD=EN=1 with Q=7, OVF=1.
   - Next edge: Q=0, OVF=0, WRAP=0.
   - LOAD=EN=1 with D=4: Q=4.
5. Full range and LIMIT=0:
   - LIMIT=255, Q=255, UP=1: Q goes to 0.
   - LIMIT=0, EN held high: Q stays 0 and WRAP stays high continuously.
6. Async reset mid-count: assert RST between edges while Q=6.
   - Q=0, NQ=255, OVF=0 with no CLK edge needed.
   - After release, counting resumes from 0.
